// File: rtl/stm32_stream_interface.sv
// Byte-wide STM32 <-> FPGA command/stream link: params write, status read, TX IQ load, RX IQ stream, bus test, info.
// Define STM32_IQ_CHECKSUM_EN to append an XOR checksum byte after every RX IQ frame.
module stm32_stream_interface #(
  parameter int RX_CHANNELS     = 2,
  parameter int SAMPLE_BYTES    = 3,
  parameter int TX_SAMPLE_BYTES = 3,
  parameter int PARAM_BYTES     = 24,
  parameter int STATUS_BYTES    = 12,
  parameter int VERSION         = 5
) (
  input  logic                                  clk_in,
  input  logic                                  reset_n,
  input  logic                                  DATA_SYNC,
  input  logic [7:0]                            DATA_BUS_IN,
  output logic [7:0]                            DATA_BUS_OUT,
  output logic                                  DATA_BUS_OE,
  input  logic [RX_CHANNELS*2*SAMPLE_BYTES*8-1:0] RX_IQ,
  input  logic [RX_CHANNELS-1:0]                rx_ch_enable,
  output logic                                  IQ_RX_READ_REQ,
  input  logic [STATUS_BYTES*8-1:0]             STATUS,
  output logic                                  status_read_done,
  output logic [PARAM_BYTES*8-1:0]              PARAMS,
  output logic                                  params_update,
  output logic [TX_SAMPLE_BYTES*8-1:0]          TX_I,
  output logic [TX_SAMPLE_BYTES*8-1:0]          TX_Q,
  output logic                                  tx_iq_valid,
  output logic [15:0]                           stage_debug
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CHB    = 2 * SAMPLE_BYTES;
  localparam int RXW    = RX_CHANNELS * CHB * 8;
  localparam int TXW    = TX_SAMPLE_BYTES * 8;
  localparam int TXN    = 2 * TX_SAMPLE_BYTES;
  localparam int TSW    = (TXN - 1) * 8;
  localparam int PSW    = (PARAM_BYTES - 1) * 8;
  localparam int STW    = STATUS_BYTES * 8;
  localparam int MAXLEN = max2(max2(PARAM_BYTES, STATUS_BYTES), max2(RX_CHANNELS * CHB + 1, TXN));
  localparam int CW     = $clog2(MAXLEN + 1);
  localparam int CHW    = (RX_CHANNELS > 1) ? $clog2(RX_CHANNELS) : 1;
  localparam int JW     = $clog2(CHB);

  localparam logic [7:0] CMD_BUS_TEST = 8'd0;
  localparam logic [7:0] CMD_PARAMS   = 8'd1;
  localparam logic [7:0] CMD_STATUS   = 8'd2;
  localparam logic [7:0] CMD_TX       = 8'd3;
  localparam logic [7:0] CMD_RX       = 8'd4;
  localparam logic [7:0] CMD_INFO     = 8'd8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BUS_TEST = 3'd1;
  localparam logic [2:0] S_PARAMS   = 3'd2;
  localparam logic [2:0] S_STATUS   = 3'd3;
  localparam logic [2:0] S_TX       = 3'd4;
  localparam logic [2:0] S_RX       = 3'd5;
  localparam logic [2:0] S_INFO     = 3'd6;

  logic [2:0]             state;
  logic [CW-1:0]          idx;
  logic [7:0]             bus_out;
  logic                   oe;
  logic                   req;
  logic                   done;
  logic [PSW-1:0]         p_shadow;
  logic [PARAM_BYTES*8-1:0] params_q;
  logic [TSW-1:0]         tx_shadow;
  logic [TXW-1:0]         tx_i_q;
  logic [TXW-1:0]         tx_q_q;
  logic [STW-1:0]         st_snap;
  logic [RXW-1:0]         rx_snap;
  logic [RX_CHANNELS-1:0] rx_mask;
  logic [CHW-1:0]         rx_ch;
  logic [JW-1:0]          rx_j;
`ifdef STM32_IQ_CHECKSUM_EN
  logic [7:0]             rx_csum;
  logic                   rx_ck;
`endif

  logic                   pw_commit;
  logic                   tx_commit;
  logic [PARAM_BYTES*8-1:0] p_cat;
  logic [TSW+7:0]         tx_cat;
  logic [CHW-1:0]         first_ch;
  logic [CHW-1:0]         next_ch;
  logic                   has_next;
  logic [CHW-1:0]         cont_ch;
  logic [JW-1:0]          cont_j;
  logic [7:0]             start_byte;
  logic [7:0]             cont_byte;
  logic                   rx_last;
  logic                   rx_restart;
  logic                   frame_start;

  // Write commits are visible in the same cycle as the final write byte, alongside their pulse.
  assign pw_commit = (state == S_PARAMS) && !DATA_SYNC && (idx == CW'(PARAM_BYTES - 1));
  assign tx_commit = (state == S_TX) && !DATA_SYNC && (idx == CW'(TXN - 1));
  assign p_cat     = {DATA_BUS_IN, p_shadow};
  assign tx_cat    = {tx_shadow, DATA_BUS_IN};

  assign PARAMS           = pw_commit ? p_cat : params_q;
  assign params_update    = pw_commit;
  assign TX_Q             = tx_commit ? tx_cat[2*TXW-1:TXW] : tx_q_q;
  assign TX_I             = tx_commit ? tx_cat[TXW-1:0] : tx_i_q;
  assign tx_iq_valid      = tx_commit;
  assign DATA_BUS_OUT     = bus_out;
  assign DATA_BUS_OE      = oe;
  assign IQ_RX_READ_REQ   = req;
  assign status_read_done = done;
  assign stage_debug      = {state, 13'(idx)};

  // RX frame walker: locate first/next enabled channel and the byte to put on the bus next.
  always_comb begin
    first_ch = '0;
    for (int i = RX_CHANNELS - 1; i >= 0; i--)
      if (rx_ch_enable[i]) first_ch = CHW'(i);
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = RX_CHANNELS - 1; i >= 0; i--)
      if (rx_mask[i] && (CHW'(i) > rx_ch)) begin
        next_ch  = CHW'(i);
        has_next = 1'b1;
      end
    if (rx_j == JW'(CHB - 1)) begin
      cont_ch = next_ch;
      cont_j  = '0;
    end else begin
      cont_ch = rx_ch;
      cont_j  = rx_j + 1'b1;
    end
    start_byte = 8'(RX_IQ >> (int'(first_ch) * CHB * 8 + (CHB - 1) * 8));
    cont_byte  = 8'(rx_snap >> (int'(cont_ch) * CHB * 8 + (CHB - 1 - int'(cont_j)) * 8));
    rx_last    = !has_next && (rx_j == JW'(CHB - 1));
`ifdef STM32_IQ_CHECKSUM_EN
    rx_restart = (rx_mask == '0) || rx_ck;
`else
    rx_restart = (rx_mask == '0) || rx_last;
`endif
    frame_start = DATA_SYNC ? (DATA_BUS_IN == CMD_RX) : ((state == S_RX) && rx_restart);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      bus_out   <= '0;
      oe        <= 1'b0;
      req       <= 1'b0;
      done      <= 1'b0;
      p_shadow  <= '0;
      params_q  <= '0;
      tx_shadow <= '0;
      tx_i_q    <= '0;
      tx_q_q    <= '0;
      st_snap   <= '0;
      rx_snap   <= '0;
      rx_mask   <= '0;
      rx_ch     <= '0;
      rx_j      <= '0;
`ifdef STM32_IQ_CHECKSUM_EN
      rx_csum   <= '0;
      rx_ck     <= 1'b0;
`endif
    end else begin
      req  <= 1'b0;
      done <= 1'b0;
      if (DATA_SYNC) begin
        idx <= '0;
        case (DATA_BUS_IN)
          CMD_BUS_TEST: begin state <= S_BUS_TEST; oe <= 1'b0; end
          CMD_PARAMS:   begin state <= S_PARAMS;   oe <= 1'b0; end
          CMD_TX:       begin state <= S_TX;       oe <= 1'b0; end
          CMD_RX:       begin state <= S_RX;       oe <= 1'b1; end
          CMD_STATUS: begin
            state   <= S_STATUS;
            oe      <= 1'b1;
            bus_out <= STATUS[STW-1 -: 8];
            st_snap <= {STATUS[STW-9:0], 8'h00};
            idx     <= CW'(1);
            done    <= (STATUS_BYTES == 1);
          end
          CMD_INFO: begin
            state   <= S_INFO;
            oe      <= 1'b1;
            bus_out <= 8'(VERSION);
            idx     <= CW'(1);
          end
          default: begin state <= S_IDLE; oe <= 1'b0; end
        endcase
      end else begin
        case (state)
          S_BUS_TEST: begin
            if (!oe) begin
              bus_out <= DATA_BUS_IN;
              oe      <= 1'b1;
            end else begin
              oe <= 1'b0;
            end
          end
          S_PARAMS: begin
            p_shadow <= {DATA_BUS_IN, p_shadow[PSW-1:8]};
            if (pw_commit) begin
              params_q <= p_cat;
              state    <= S_IDLE;
              idx      <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          S_STATUS: begin
            if (idx == CW'(STATUS_BYTES)) begin
              oe    <= 1'b0;
              state <= S_IDLE;
              idx   <= '0;
            end else begin
              bus_out <= st_snap[STW-1 -: 8];
              st_snap <= st_snap << 8;
              idx     <= idx + 1'b1;
              done    <= (idx == CW'(STATUS_BYTES - 1));
            end
          end
          S_TX: begin
            tx_shadow <= {tx_shadow[TSW-9:0], DATA_BUS_IN};
            if (tx_commit) begin
              tx_q_q <= tx_cat[2*TXW-1:TXW];
              tx_i_q <= tx_cat[TXW-1:0];
              state  <= S_IDLE;
              idx    <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          S_RX: begin
            if (!rx_restart) begin
`ifdef STM32_IQ_CHECKSUM_EN
              if (rx_last) begin
                bus_out <= rx_csum;
                rx_ck   <= 1'b1;
              end else begin
                bus_out <= cont_byte;
                rx_csum <= rx_csum ^ cont_byte;
                rx_ch   <= cont_ch;
                rx_j    <= cont_j;
              end
`else
              bus_out <= cont_byte;
              rx_ch   <= cont_ch;
              rx_j    <= cont_j;
`endif
            end
          end
          S_INFO: begin
            if (idx == CW'(1)) begin
              bus_out <= 8'(RX_CHANNELS);
              idx     <= CW'(2);
            end else if (idx == CW'(2)) begin
              bus_out <= 8'(SAMPLE_BYTES);
              idx     <= CW'(3);
            end else begin
              oe    <= 1'b0;
              state <= S_IDLE;
              idx   <= '0;
            end
          end
          default: oe <= 1'b0;
        endcase
      end
      // A zero mask idles the stream with 0x00 and retries on every following cycle.
      if (frame_start) begin
        rx_mask <= rx_ch_enable;
`ifdef STM32_IQ_CHECKSUM_EN
        rx_ck   <= 1'b0;
        rx_csum <= start_byte;
`endif
        if (rx_ch_enable != '0) begin
          rx_snap <= RX_IQ;
          rx_ch   <= first_ch;
          rx_j    <= '0;
          bus_out <= start_byte;
          req     <= 1'b1;
        end else begin
          bus_out <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_stm32_stream_interface.sv
// Directed self-checking bench for stm32_stream_interface at default parameters.
// Follows STM32_IQ_CHECKSUM_EN to expect the extra RX checksum byte when it is defined.
module tb_stm32_stream_interface;

`ifdef STM32_IQ_CHECKSUM_EN
  localparam int FL = 7;
`else
  localparam int FL = 6;
`endif

  logic         clk_in = 1'b0;
  logic         reset_n;
  logic         DATA_SYNC;
  logic [7:0]   DATA_BUS_IN;
  logic [7:0]   DATA_BUS_OUT;
  logic         DATA_BUS_OE;
  logic [95:0]  RX_IQ;
  logic [1:0]   rx_ch_enable;
  logic         IQ_RX_READ_REQ;
  logic [95:0]  STATUS;
  logic         status_read_done;
  logic [191:0] PARAMS;
  logic         params_update;
  logic [23:0]  TX_I;
  logic [23:0]  TX_Q;
  logic         tx_iq_valid;
  logic [15:0]  stage_debug;

  int nvec = 0;
  int nerr = 0;
  logic [191:0] exp_params;
  logic [7:0]   exp_b;
  logic [7:0]   old_fr [6] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
  logic [7:0]   new_fr [6] = '{8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};
  logic [7:0]   both_fr [12] = '{8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22,
                                 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

  stm32_stream_interface dut (
    .clk_in(clk_in), .reset_n(reset_n), .DATA_SYNC(DATA_SYNC), .DATA_BUS_IN(DATA_BUS_IN),
    .DATA_BUS_OUT(DATA_BUS_OUT), .DATA_BUS_OE(DATA_BUS_OE), .RX_IQ(RX_IQ),
    .rx_ch_enable(rx_ch_enable), .IQ_RX_READ_REQ(IQ_RX_READ_REQ), .STATUS(STATUS),
    .status_read_done(status_read_done), .PARAMS(PARAMS), .params_update(params_update),
    .TX_I(TX_I), .TX_Q(TX_Q), .tx_iq_valid(tx_iq_valid), .stage_debug(stage_debug)
  );

  always #5 clk_in = ~clk_in;

  // One bus cycle: inputs change just after the edge, outputs are sampled 3 units after it.
  task automatic apply_stimulus(input logic sync, input logic [7:0] data);
    @(posedge clk_in);
    #1;
    DATA_SYNC   = sync;
    DATA_BUS_IN = data;
    #2;
  endtask

  task automatic check_output(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    DATA_SYNC    = 1'b0;
    DATA_BUS_IN  = 8'h00;
    RX_IQ        = '0;
    rx_ch_enable = '0;
    STATUS       = '0;
    reset_n      = 1'b1;
    #2 reset_n   = 1'b0;
    repeat (2) @(posedge clk_in);
    #3;
    check_output("reset_oe", DATA_BUS_OE, 1'b0);
    check_output("reset_out", DATA_BUS_OUT, 8'h00);
    check_output("reset_params", PARAMS, '0);
    check_output("reset_tx", {TX_Q, TX_I}, '0);
    check_output("reset_pulses", {params_update, tx_iq_valid, status_read_done, IQ_RX_READ_REQ}, 4'b0000);
    check_output("reset_stage", stage_debug, 16'h0000);
    reset_n = 1'b1;

    $display("[TB] params write");
    exp_params = '0;
    apply_stimulus(1'b1, 8'h01);
    for (int k = 1; k <= 24; k++) begin
      apply_stimulus(1'b0, 8'(k));
      exp_params[8*(k-1) +: 8] = 8'(k);
      check_output("pw_update", params_update, (k == 24));
      check_output("pw_oe", DATA_BUS_OE, 1'b0);
    end
    check_output("pw_byte0", PARAMS[7:0], 8'h01);
    check_output("pw_byte23", PARAMS[191:184], 8'h18);
    check_output("pw_all", PARAMS, exp_params);
    apply_stimulus(1'b0, 8'h00);
    check_output("pw_update_after", params_update, 1'b0);
    check_output("pw_held", PARAMS, exp_params);

    $display("[TB] params abort then info");
    apply_stimulus(1'b1, 8'h01);
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(1'b0, 8'hF0 + 8'(k));
      check_output("pwa_update", params_update, 1'b0);
    end
    apply_stimulus(1'b1, 8'h08);
    check_output("pwa_update_sync", params_update, 1'b0);
    apply_stimulus(1'b0, 8'h00);
    check_output("info0", {DATA_BUS_OE, DATA_BUS_OUT}, {1'b1, 8'h05});
    apply_stimulus(1'b0, 8'h00);
    check_output("info1", {DATA_BUS_OE, DATA_BUS_OUT}, {1'b1, 8'h02});
    apply_stimulus(1'b0, 8'h00);
    check_output("info2", {DATA_BUS_OE, DATA_BUS_OUT}, {1'b1, 8'h03});
    apply_stimulus(1'b0, 8'h00);
    check_output("info_oe_off", DATA_BUS_OE, 1'b0);
    check_output("pwa_params", PARAMS, exp_params);

    $display("[TB] tx iq");
    apply_stimulus(1'b1, 8'h03);
    apply_stimulus(1'b0, 8'h12); check_output("tx_valid1", tx_iq_valid, 1'b0);
    apply_stimulus(1'b0, 8'h34); check_output("tx_valid2", tx_iq_valid, 1'b0);
    apply_stimulus(1'b0, 8'h56); check_output("tx_valid3", tx_iq_valid, 1'b0);
    apply_stimulus(1'b0, 8'hAB); check_output("tx_valid4", tx_iq_valid, 1'b0);
    apply_stimulus(1'b0, 8'hCD); check_output("tx_valid5", tx_iq_valid, 1'b0);
    apply_stimulus(1'b0, 8'hEF);
    check_output("tx_valid6", tx_iq_valid, 1'b1);
    check_output("tx_q", TX_Q, 24'h123456);
    check_output("tx_i", TX_I, 24'hABCDEF);
    apply_stimulus(1'b0, 8'h00);
    check_output("tx_valid7", tx_iq_valid, 1'b0);
    check_output("tx_held", {TX_Q, TX_I}, 48'h123456ABCDEF);
    apply_stimulus(1'b1, 8'h03);
    for (int k = 1; k <= 5; k++) apply_stimulus(1'b0, 8'h11 * 8'(k));
    apply_stimulus(1'b1, 8'hFF);
    check_output("txa_valid", tx_iq_valid, 1'b0);
    apply_stimulus(1'b0, 8'h66);
    check_output("txa_valid_after", tx_iq_valid, 1'b0);
    check_output("txa_oe", DATA_BUS_OE, 1'b0);
    check_output("txa_held", {TX_Q, TX_I}, 48'h123456ABCDEF);

    $display("[TB] status read");
    STATUS = 96'h0102030405060708090A0B0C;
    apply_stimulus(1'b1, 8'h02);
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus(1'b0, 8'h00);
      if (k == 1) STATUS = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
      check_output("st_byte", {DATA_BUS_OE, DATA_BUS_OUT}, {1'b1, 8'(k)});
      check_output("st_done", status_read_done, (k == 12));
    end
    apply_stimulus(1'b0, 8'h00);
    check_output("st_oe_off", DATA_BUS_OE, 1'b0);
    check_output("st_done_off", status_read_done, 1'b0);

    $display("[TB] bus test");
    apply_stimulus(1'b1, 8'h00);
    apply_stimulus(1'b0, 8'h55); check_output("bt_oe1", DATA_BUS_OE, 1'b0);
    apply_stimulus(1'b0, 8'h00); check_output("bt_echo1", {DATA_BUS_OE, DATA_BUS_OUT}, {1'b1, 8'h55});
    apply_stimulus(1'b0, 8'hAA); check_output("bt_oe3", DATA_BUS_OE, 1'b0);
    apply_stimulus(1'b0, 8'h00); check_output("bt_echo2", {DATA_BUS_OE, DATA_BUS_OUT}, {1'b1, 8'hAA});

    $display("[TB] rx stream, channel 1 only");
    RX_IQ        = {24'h0A0B0C, 24'h0D0E0F, 24'h111111, 24'h222222};
    rx_ch_enable = 2'b10;
    apply_stimulus(1'b1, 8'h04);
    check_output("rx_req_c0", IQ_RX_READ_REQ, 1'b0);
    for (int c = 1; c <= 3 * FL; c++) begin
      int p;
      int fr;
      apply_stimulus(1'b0, 8'h00);
      if (c == 2) RX_IQ = {24'h1A1B1C, 24'h1D1E1F, 24'h333333, 24'h444444};
      p  = (c - 1) % FL;
      fr = (c - 1) / FL;
      exp_b = (p == 6) ? 8'h01 : ((fr == 0) ? old_fr[p] : new_fr[p]);
      check_output("rx1_byte", {DATA_BUS_OE, DATA_BUS_OUT}, {1'b1, exp_b});
      check_output("rx1_req", IQ_RX_READ_REQ, (p == 0));
    end

    $display("[TB] rx stream, both channels");
    RX_IQ        = {24'h0A0B0C, 24'h0D0E0F, 24'h111111, 24'h222222};
    rx_ch_enable = 2'b11;
    apply_stimulus(1'b1, 8'h04);
    for (int c = 1; c <= 12 + FL - 5; c++) begin
      int p;
      apply_stimulus(1'b0, 8'h00);
      p = (c - 1) % (FL + 6);
      if (p < 12) begin
        check_output("rx2_byte", DATA_BUS_OUT, both_fr[p]);
      end else begin
        check_output("rx2_cksum", DATA_BUS_OUT, 8'h11 ^ 8'h22 ^ 8'h01);
      end
      check_output("rx2_req", IQ_RX_READ_REQ, (p == 0));
    end

    $display("[TB] rx stream, zero mask then enable");
    rx_ch_enable = 2'b00;
    apply_stimulus(1'b1, 8'h04);
    apply_stimulus(1'b0, 8'h00);
    check_output("rx0_idle1", {DATA_BUS_OE, DATA_BUS_OUT, IQ_RX_READ_REQ}, {1'b1, 8'h00, 1'b0});
    apply_stimulus(1'b0, 8'h00);
    check_output("rx0_idle2", {DATA_BUS_OE, DATA_BUS_OUT, IQ_RX_READ_REQ}, {1'b1, 8'h00, 1'b0});
    rx_ch_enable = 2'b01;
    apply_stimulus(1'b0, 8'h00);
    check_output("rx0_start", {DATA_BUS_OE, DATA_BUS_OUT, IQ_RX_READ_REQ}, {1'b1, 8'h11, 1'b1});
    apply_stimulus(1'b0, 8'h00);
    check_output("rx0_next", {DATA_BUS_OUT, IQ_RX_READ_REQ}, {8'h11, 1'b0});

    $display("[TB] async reset mid stream");
    #1 reset_n = 1'b0;
    #1;
    check_output("rst_oe", DATA_BUS_OE, 1'b0);
    check_output("rst_out", DATA_BUS_OUT, 8'h00);
    check_output("rst_params", PARAMS, '0);
    check_output("rst_tx", {TX_Q, TX_I}, '0);
    check_output("rst_req", IQ_RX_READ_REQ, 1'b0);
    @(posedge clk_in);
    #3 reset_n = 1'b1;
    apply_stimulus(1'b0, 8'h00);
    check_output("rst_stays_idle", DATA_BUS_OE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/stm32_stream_interface.md
Name: stm32_stream_interface

Overview:
- Parametrised byte-wide command/streaming link between the STM32 host and the FPGA DSP core; successor to the fixed 2-channel, 24-bit host interface.
- Decodes a command byte strobed by DATA_SYNC, then runs one of: params write, status read, TX IQ write, RX IQ stream, bus test, info.
- Generalised in RX channel count, sample width and param/status length; adds atomic param commit, abort-safe TX load and per-channel RX masking.

Parameters:
RX_CHANNELS, 2, number of RX IQ channel pairs (1..4)
SAMPLE_BYTES, 3, bytes per RX I or Q sample (2..4)
TX_SAMPLE_BYTES, 3, bytes per TX I or Q sample (2..4)
PARAM_BYTES, 24, bytes written by the params command
STATUS_BYTES, 12, bytes returned by the status command
VERSION, 5, first info byte

Ports:
clk_in  in  1  bus clock
reset_n  in  1  asynchronous active-low reset
DATA_SYNC  in  1  command strobe; DATA_BUS_IN holds the command byte in the same cycle
DATA_BUS_IN  in  8  host-to-FPGA byte
DATA_BUS_OUT  out  8  FPGA-to-host byte
DATA_BUS_OE  out  1  1 = FPGA drives the bus (tristate is at top level)
RX_IQ  in  RX_CHANNELS*2*SAMPLE_BYTES*8  {chN Q, chN I, ..., ch0 Q, ch0 I}
rx_ch_enable  in  RX_CHANNELS  per-channel stream mask
IQ_RX_READ_REQ  out  1  one-cycle pulse: RX FIFO pop
STATUS  in  STATUS_BYTES*8  status snapshot source
status_read_done  out  1  one-cycle pulse on the last status byte (min/max reset)
PARAMS  out  PARAM_BYTES*8  committed params; byte 0 in [7:0]
params_update  out  1  one-cycle pulse on commit
TX_I, TX_Q  out  TX_SAMPLE_BYTES*8 each  signed TX sample
tx_iq_valid  out  1  one-cycle pulse on new TX sample
stage_debug  out  16  current state/byte index

Behaviour:
- Reset: all outputs 0, DATA_BUS_OE=0, state IDLE, shadow registers 0.
- DATA_SYNC=1 has top priority in any state: aborts the current transfer and decodes DATA_BUS_IN. Call this cycle 0; byte k of the transfer occupies cycle k (k>=1).
- Command codes:
  - 0 BUS_TEST.
  - 1 PARAMS_WR.
  - 2 STATUS_RD.
  - 3 TX_IQ.
  - 4 RX_IQ.
  - 8 INFO.
  - Any other code: IDLE with OE=0.
- Read commands register OE=1 and the first byte at the cycle-0 edge, so both are valid in cycle 1. Write commands keep OE=0 and sample DATA_BUS_IN in cycles 1..N.
- PARAMS_WR:
  - Bytes are written into a shadow register, byte 0 first.
  - On byte PARAM_BYTES-1, shadow is copied to PARAMS and params_update pulses.
  - Abort before the last byte: PARAMS unchanged, no pulse.
  - The state then goes to IDLE.
- STATUS_RD:
  - STATUS is snapshotted in cycle 0.
  - Bytes are sent highest byte first.
  - status_read_done pulses with the last byte.
  - Next cycle: OE=0, IDLE.
- TX_IQ:
  - 2*TX_SAMPLE_BYTES bytes in order Q then I, MSB first.
  - On the last byte, TX_I/TX_Q update together and tx_iq_valid pulses.
  - Abort: no update.
  - Then IDLE.
- RX_IQ:
  - Continuous frames until DATA_SYNC.
  - At each frame start: latch rx_ch_enable and snapshot RX_IQ; IQ_RX_READ_REQ pulses in that same cycle.
  - Frame content: enabled channels in ascending order; per channel Q then I, each MSB first, SAMPLE_BYTES bytes each.
  - The cycle after the frame's last byte is the first byte of the next frame. There are no gap bytes.
  - Mask latched as 0: drive 0x00 each cycle, no REQ, re-check the mask each cycle.
- BUS_TEST:
  - Odd cycles: OE=0, capture DATA_BUS_IN.
  - Even cycles: OE=1, drive the captured byte.
  - Repeats until DATA_SYNC.
- INFO: sends VERSION, RX_CHANNELS, SAMPLE_BYTES, then OE=0, IDLE.
- Widths: byte counters sized for the max of PARAM_BYTES, STATUS_BYTES and frame length. No wrap beyond defined lengths.
- Async reset mid-transfer: immediate return to reset values; PARAMS returns to 0.

Optional Feature:
- STM32_IQ_CHECKSUM_EN defined: each RX_IQ frame is followed by one extra byte, the XOR of all data bytes in that frame. Zero-mask idle bytes carry no checksum.
- Undefined: no checksum byte; frames are data only.

Test Plan:
- PARAMS_WR with PARAM_BYTES=24, bytes 0x01..0x18 -> PARAMS[7:0]=0x01, PARAMS[191:184]=0x18, single params_update pulse in cycle 24.
- PARAMS_WR aborted by DATA_SYNC(cmd 8) after 10 bytes -> PARAMS unchanged, no pulse, INFO returns 0x05,0x02,0x03.
- TX_IQ bytes 12 34 56 AB CD EF -> TX_Q=0x123456, TX_I=0xABCDEF, tx_iq_valid for 1 cycle in cycle 6; abort after 5 bytes -> no change.
- RX_IQ, RX_CHANNELS=2, mask=2'b10, ch1 Q=0x0A0B0C, I=0x0D0E0F -> repeating 0A 0B 0C 0D 0E 0F, REQ pulse every 6 cycles (7 with checksum; checksum byte 0x0F^0x0F... = XOR of the 6 data bytes = 0x01).
- STATUS_RD with STATUS=96'h0102...0C -> 01..0C out, status_read_done in cycle 12, OE low in cycle 13.
- BUS_TEST: host 0x55 then 0xAA -> echo 0x55 in cycle 2 and 0xAA in cycle 4; reset_n low mid-RX stream -> OE=0 immediately.
